// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Used by fetch_unit and its buffering FIFO (fetch_fifo).
package fetch_unit_pkg;

  localparam int          INSTR_W = 32;
  localparam logic [31:0] PC_INCR = 32'd4;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; the low two bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, occupancy count and a ready/valid pop port.
// The head output holds its last presented value while the FIFO is empty.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     ready_i,
  output logic                     valid_o,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [WIDTH-1:0] last_q;
  logic             pop;

  assign valid_o = (count_q != '0);
  assign pop     = valid_o & ready_i;
  assign count_o = count_q;
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : last_q;

  // NOTE: storage is deliberately not reset; the count gates every read, so
  // stale contents are never presented and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      if (valid_o) begin
        last_q <= mem_q[rd_ptr_q];
      end
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
        if (pop)    rd_ptr_q <= rd_ptr_q + PTR_ONE;
        case ({push_i, pop})
          2'b10:   count_q <= count_q + CNT_ONE;
          2'b01:   count_q <= count_q - CNT_ONE;
          default: count_q <= count_q;
        endcase
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, req/ack imem port, buffering FIFO.
// Define FETCH_STATS_EN to add saturating fetch/flush/drop counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [15:0] stat_flushes,
  output logic [15:0] stat_drops
`endif
);

  localparam int             CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  fetch_state_e     state_q;
  logic             req_q;
  logic [31:0]      addr_q;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             drop_q, drop_d;

  logic             ack_fire, push, pop;
  logic [CNT_W-1:0] count, count_after;
  fetch_entry_t     push_entry, head_entry;

  assign imem_req  = req_q;
  assign imem_addr = addr_q;

  assign ack_fire = req_q & imem_ack;
  // A redirect in the ack cycle discards the returning word directly.
  assign push     = ack_fire & ~drop_q & ~redirect_valid;
  assign pop      = inst_valid & inst_ready;

  assign push_entry = '{pc: fetch_pc_q, instr: imem_rdata};

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    count_after = count;
    fetch_pc_d  = fetch_pc_q;
    drop_d      = drop_q;

    if (redirect_valid) begin
      count_after = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_after = count + CNT_ONE;
        2'b01:   count_after = count - CNT_ONE;
        default: count_after = count;
      endcase
    end

    if (redirect_valid) begin
      fetch_pc_d = align_pc(redirect_pc);
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + PC_INCR;
    end

    // Only the single in-flight response can be stale, so drop is one bit.
    if (ack_fire) begin
      drop_d = 1'b0;
    end else if (redirect_valid && req_q) begin
      drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      drop_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
    end
  end

  // Request FSM; imem_req/imem_addr are registered here so neither inst_ready
  // nor imem_ack reaches them combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
    end else begin
      case (state_q)
        IDLE: begin
          if (count < DEPTH_CNT) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            addr_q  <= fetch_pc_d;
          end
        end
        REQ: begin
          if (imem_ack) begin
            if (count_after < DEPTH_CNT) begin
              addr_q <= fetch_pc_d;
            end else begin
              state_q <= IDLE;
              req_q   <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_data_i (push_entry),
    .ready_i     (inst_ready),
    .valid_o     (inst_valid),
    .head_o      (head_entry),
    .count_o     (count)
  );

  assign inst_pc   = head_entry.pc;
  assign inst_data = head_entry.instr;

`ifdef FETCH_STATS_EN
  logic [31:0] fetched_q;
  logic [15:0] flushes_q, drops_q;
  logic        drop_event;

  assign drop_event = ack_fire & (drop_q | redirect_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      fetched_q <= '0;
      flushes_q <= '0;
      drops_q   <= '0;
    end else begin
      if (push && (fetched_q != '1))           fetched_q <= fetched_q + 32'd1;
      if (redirect_valid && (flushes_q != '1)) flushes_q <= flushes_q + 16'd1;
      if (drop_event && (drops_q != '1))       drops_q   <= drops_q + 16'd1;
    end
  end

  assign stat_fetched = fetched_q;
  assign stat_flushes = flushes_q;
  assign stat_drops   = drops_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// traffic compared every cycle against a queue-based behavioural model.
module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [15:0] stat_flushes;
  logic [15:0] stat_drops;
`endif

  fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_flushes   (stat_flushes),
    .stat_drops     (stat_drops)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a ^ {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Behavioural model: a queue of buffered {pc, word}, the outstanding request,
  // the next fetch address and the pending-drop flag.
  logic [31:0] q_pc[$];
  logic [31:0] q_ins[$];
  bit          m_req, m_drop;
  logic [31:0] m_addr, m_pc, m_last_pc, m_last_ins;
  int          m_fetched, m_flushes, m_drops;
  bit          cmp_en = 1'b0;

  // Driver state
  bit          d_reset, d_ack, d_ready, d_redir;
  logic [31:0] d_rpc;
  int          wait_n, wcnt;

  task automatic model_edge();
    int cnt_pre;
    bit fire, pushed;
    if (d_reset) begin
      m_req = 0; m_drop = 0; m_pc = RESET_PC; m_addr = RESET_PC;
      q_pc.delete(); q_ins.delete();
      m_last_pc = '0; m_last_ins = '0;
      m_fetched = 0; m_flushes = 0; m_drops = 0;
      return;
    end
    cnt_pre = q_pc.size();
    if (cnt_pre > 0) begin
      m_last_pc  = q_pc[0];
      m_last_ins = q_ins[0];
      if (d_ready) begin
        void'(q_pc.pop_front());
        void'(q_ins.pop_front());
      end
    end
    fire   = m_req && d_ack;
    pushed = fire && !m_drop && !d_redir;
    if (d_redir) begin
      q_pc.delete(); q_ins.delete();
      if (m_flushes < 65535) m_flushes++;
    end
    if (pushed) begin
      q_pc.push_back(m_pc);
      q_ins.push_back(mem_word(m_pc));
      m_fetched++;
      m_pc = m_pc + 32'd4;
    end
    if (fire && (m_drop || d_redir) && m_drops < 65535) m_drops++;
    if (d_redir) m_pc = d_rpc & ~32'h3;
    if (fire) m_drop = 0;
    else if (d_redir && m_req) m_drop = 1;
    if (!m_req) begin
      if (cnt_pre < DEPTH) begin
        m_req  = 1;
        m_addr = m_pc;
      end
    end else if (fire) begin
      if (q_pc.size() < DEPTH) m_addr = m_pc;
      else m_req = 0;
    end
  endtask

  // Inputs are applied #1 after a rising edge; the model advances on the edge.
  task automatic step();
    reset          = d_reset;
    imem_ack       = d_ack;
    inst_ready     = d_ready;
    redirect_valid = d_redir;
    redirect_pc    = d_rpc;
    imem_rdata     = mem_word(imem_addr);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Memory with wait_n wait states per request.
  task automatic mem_drive();
    if (imem_req) begin
      if (wcnt >= wait_n) begin
        d_ack = 1; wcnt = 0;
      end else begin
        d_ack = 0; wcnt++;
      end
    end else begin
      d_ack = 0; wcnt = 0;
    end
  endtask

  task automatic do_reset(input int n);
    d_reset = 1; d_ack = 0; d_redir = 0; d_ready = 0; d_rpc = '0;
    repeat (n) step();
    d_reset = 0; wcnt = 0;
  endtask

  // Single compare process: checks every output against the model each cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_inst_valid", 32'(inst_valid), 32'(q_pc.size() != 0));
      if (q_pc.size() != 0) begin
        check("cmp_inst_pc", inst_pc, q_pc[0]);
        check("cmp_inst_data", inst_data, q_ins[0]);
      end else begin
        check("cmp_hold_pc", inst_pc, m_last_pc);
        check("cmp_hold_data", inst_data, m_last_ins);
      end
      check("cmp_imem_req", 32'(imem_req), 32'(m_req));
      if (m_req) check("cmp_imem_addr", imem_addr, m_addr);
`ifdef FETCH_STATS_EN
      check("cmp_stat_fetched", stat_fetched, 32'(m_fetched));
      check("cmp_stat_flushes", 32'(stat_flushes), 32'(m_flushes));
      check("cmp_stat_drops", 32'(stat_drops), 32'(m_drops));
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int  pulses;
    bit  found;
    int  rdy_pct;

    reset = 1; imem_ack = 0; inst_ready = 0; redirect_valid = 0;
    redirect_pc = '0; imem_rdata = '0;
    wait_n = 0; wcnt = 0;
    d_reset = 1; d_ack = 0; d_ready = 0; d_redir = 0; d_rpc = '0;
    step();
    cmp_en = 1;

    // 1: zero-wait memory, always-ready consumer
    do_reset(2);
    check("t1_reset_req", 32'(imem_req), 32'd0);
    check("t1_reset_valid", 32'(inst_valid), 32'd0);
    check("t1_reset_pc", inst_pc, 32'd0);
    d_ready = 1; d_ack = 1;
    step();
    check("t1_req_cyc1", 32'(imem_req), 32'd1);
    check("t1_addr_cyc1", imem_addr, 32'h0);
    check("t1_novalid_cyc1", 32'(inst_valid), 32'd0);
    step();
    check("t1_valid_cyc2", 32'(inst_valid), 32'd1);
    check("t1_pc_cyc2", inst_pc, 32'h0);
    check("t1_data_cyc2", inst_data, mem_word(32'h0));
    check("t1_addr_cyc2", imem_addr, 32'h4);
    for (int k = 1; k <= 6; k++) begin
      step();
      check("t1_seq_addr", imem_addr, 32'(4 * (k + 1)));
      check("t1_seq_pc", inst_pc, 32'(4 * k));
    end

    // 2: consumer stalled -> exactly four fetches, then resume at 0x10
    do_reset(2);
    d_ready = 0; d_ack = 1;
    repeat (5) step();
    check("t2_full_req", 32'(imem_req), 32'd0);
    check("t2_full_head", inst_pc, 32'h0);
    repeat (3) step();
    check("t2_full_still_idle", 32'(imem_req), 32'd0);
    d_ready = 1;
    step();
    check("t2_pop_head", inst_pc, 32'h4);
    check("t2_pop_noreq", 32'(imem_req), 32'd0);
    step();
    check("t2_resume_req", 32'(imem_req), 32'd1);
    check("t2_resume_addr", imem_addr, 32'h10);
    check("t2_resume_head", inst_pc, 32'h8);
    repeat (6) step();

    // 3: three wait states -> one instruction per four cycles
    do_reset(2);
    d_ready = 1; wait_n = 3; pulses = 0;
    for (int i = 0; i < 40; i++) begin
      mem_drive();
      step();
      if (inst_valid) pulses++;
    end
    check("t3_pulses", 32'(pulses), 32'd9);

    // 4: redirect to 0x100 while the request to 0x20 waits
    do_reset(2);
    d_ready = 1; d_ack = 1; found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (imem_req && imem_addr == 32'h20) found = 1;
    end
    check("t4_reach_0x20", 32'(found), 32'd1);
    d_ack = 0; d_redir = 1; d_rpc = 32'h100;
    step();
    d_redir = 0;
    check("t4_flush_valid", 32'(inst_valid), 32'd0);
    check("t4_hold_req", 32'(imem_req), 32'd1);
    check("t4_hold_addr", imem_addr, 32'h20);
    repeat (2) step();
    check("t4_still_addr", imem_addr, 32'h20);
    d_ack = 1;
    step();
    check("t4_drop_valid", 32'(inst_valid), 32'd0);
    check("t4_new_addr", imem_addr, 32'h100);
    step();
    check("t4_first_valid", 32'(inst_valid), 32'd1);
    check("t4_first_pc", inst_pc, 32'h100);
    check("t4_first_data", inst_data, mem_word(32'h100));

    // 5: redirect coincident with ack and pop; unaligned target
    repeat (2) step();
    check("t5_pre_valid", 32'(inst_valid), 32'd1);
    d_redir = 1; d_rpc = 32'h2003;
    step();
    d_redir = 0;
    check("t5_flush_valid", 32'(inst_valid), 32'd0);
    check("t5_req_addr", imem_addr, 32'h2000);
    step();
    check("t5_first_pc", inst_pc, 32'h2000);

    // 6: reset during a wait state, then a late ack
    wait_n = 3; wcnt = 0; found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      mem_drive();
      step();
      if (imem_req && wcnt == 2) found = 1;
    end
    check("t6_reach_wait", 32'(found), 32'd1);
    d_reset = 1; d_ack = 0; d_redir = 0;
    step();
    check("t6_req_dropped", 32'(imem_req), 32'd0);
    check("t6_valid_cleared", 32'(inst_valid), 32'd0);
`ifdef FETCH_STATS_EN
    check("t6_stat_fetched", stat_fetched, 32'd0);
    check("t6_stat_flushes", 32'(stat_flushes), 32'd0);
    check("t6_stat_drops", 32'(stat_drops), 32'd0);
`endif
    d_reset = 0; d_ack = 1; wcnt = 0;
    step();
    check("t6_ack_ignored", 32'(inst_valid), 32'd0);
    check("t6_restart_req", 32'(imem_req), 32'd1);
    check("t6_restart_addr", imem_addr, RESET_PC);
    step();
    check("t6_restart_pc", inst_pc, RESET_PC);

    // Randomized traffic, including redirects near the top of the address space
    for (int seg = 0; seg < 6; seg++) begin
      case (seg % 3)
        0:       rdy_pct = 90;
        1:       rdy_pct = 35;
        default: rdy_pct = 10;
      endcase
      for (int i = 0; i < 500; i++) begin
        d_reset = ($urandom_range(0, 399) == 0);
        d_ready = ($urandom_range(0, 99) < rdy_pct);
        d_ack   = ($urandom_range(0, 2) != 0);
        d_redir = ($urandom_range(0, 24) == 0);
        if ($urandom_range(0, 1) == 0) d_rpc = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
        else                           d_rpc = $urandom;
        step();
      end
    end
    d_reset = 0; d_redir = 0; d_ack = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
